// File: rtl/hls_pkg.sv
// Shared types and constants for the HLS job sequencer and the command front end.
package hls_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        RUN   = 2'd2,
        RESP  = 2'd3
    } hls_seq_state_t;

    localparam logic MODE_DOT = 1'b0;
    localparam logic MODE_EUC = 1'b1;

    localparam logic [7:0] CMD_DOT = 8'd6;
    localparam logic [7:0] CMD_EUC = 8'd7;

    // Job is in flight: latency and timeout counters advance only here.
    function automatic logic seq_active(hls_seq_state_t s);
        return (s == START) || (s == RUN);
    endfunction

endpackage

// File: rtl/hls_job_sequencer_if.sv
// ap_ctrl_hs handshake, mode and BRAM port-B ownership between sequencer and HLS core.
interface hls_job_sequencer_if #(
    parameter int RESULT_WIDTH = 32
);
    logic                    ap_start;
    logic                    ap_ready;
    logic                    ap_done;
    logic [RESULT_WIDTH-1:0] hls_result;
    logic                    hls_mode;
    logic                    bram_sel;

    modport master (
        output ap_start, hls_mode, bram_sel,
        input  ap_ready, ap_done, hls_result
    );

    modport slave (
        input  ap_start, hls_mode, bram_sel,
        output ap_ready, ap_done, hls_result
    );
endinterface

// File: rtl/hls_job_sequencer_sat_counter.sv
// Up-counter with synchronous clear and enable that sticks at all-ones.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] cnt_o
);
    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
endmodule

// File: rtl/hls_job_sequencer.sv
// Runs one dot/Euclidean job at a time on the HLS core, latches its result,
// measures latency and aborts jobs that exceed TIMEOUT_CYCLES.
//
// state | meaning
// IDLE  | waiting for cmd_valid; debug readout owns BRAM port B
// START | ap_start high until the core samples it (ap_ready)
// RUN   | core computing; waiting for ap_done or timeout
// RESP  | result (or timeout) presented until res_ack
module hls_job_sequencer
    import hls_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1_000_000,
    parameter int RESULT_WIDTH   = 32,
    parameter int CYC_WIDTH      = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid_i,
    input  logic                    cmd_mode_i,
    output logic                    cmd_ready_o,
    hls_job_sequencer_if.master     core,
    output logic                    busy_o,
    output logic                    res_valid_o,
    input  logic                    res_ack_i,
    output logic [RESULT_WIDTH-1:0] res_data_o,
    output logic                    res_mode_o,
    output logic                    res_timeout_o,
    output logic [CYC_WIDTH-1:0]    last_cycles_o
);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    hls_seq_state_t          state_q;
    logic                    ap_start_q, bram_sel_q, hls_mode_q;
    logic                    res_valid_q, res_timeout_q, res_mode_q;
    logic [RESULT_WIDTH-1:0] res_data_q;
    logic [CYC_WIDTH-1:0]    last_cycles_q;

    logic                    accept, active, tmo_hit;
    logic [CYC_WIDTH-1:0]    cyc_cnt, cyc_plus1;
    logic [TMO_W-1:0]        tmo_cnt;

    assign accept    = (state_q == IDLE) && cmd_valid_i;
    assign active    = seq_active(state_q);
    assign tmo_hit   = (tmo_cnt == TMO_LAST);
    // The sampling cycle of ap_done itself is part of the latency.
    assign cyc_plus1 = (cyc_cnt == '1) ? cyc_cnt : cyc_cnt + CYC_WIDTH'(1);

    sat_counter #(.WIDTH(CYC_WIDTH)) u_lat_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (accept),
        .en_i  (active),
        .cnt_o (cyc_cnt)
    );

    sat_counter #(.WIDTH(TMO_W)) u_tmo_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (accept),
        .en_i  (active),
        .cnt_o (tmo_cnt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            ap_start_q    <= 1'b0;
            bram_sel_q    <= 1'b0;
            hls_mode_q    <= MODE_DOT;
            res_valid_q   <= 1'b0;
            res_timeout_q <= 1'b0;
            res_mode_q    <= MODE_DOT;
            res_data_q    <= '0;
            last_cycles_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_valid_i) begin
                        hls_mode_q <= cmd_mode_i;
                        bram_sel_q <= 1'b1;
                        ap_start_q <= 1'b1;
                        state_q    <= START;
                    end
                end
                START, RUN: begin
                    // ap_done beats an expiring timeout on the same cycle.
                    if (core.ap_done) begin
                        ap_start_q    <= 1'b0;
                        bram_sel_q    <= 1'b0;
                        res_data_q    <= core.hls_result;
                        res_mode_q    <= hls_mode_q;
                        res_timeout_q <= 1'b0;
                        last_cycles_q <= cyc_plus1;
                        res_valid_q   <= 1'b1;
                        state_q       <= RESP;
                    end else if (tmo_hit) begin
                        ap_start_q    <= 1'b0;
                        bram_sel_q    <= 1'b0;
                        res_data_q    <= '0;
                        res_timeout_q <= 1'b1;
                        last_cycles_q <= '1;
                        res_valid_q   <= 1'b1;
                        state_q       <= RESP;
                    end else if ((state_q == START) && core.ap_ready) begin
                        ap_start_q <= 1'b0;
                        state_q    <= RUN;
                    end
                end
                RESP: begin
                    if (res_ack_i) begin
                        res_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmd_ready_o   = (state_q == IDLE);
    assign busy_o        = (state_q != IDLE);
    assign core.ap_start = ap_start_q;
    assign core.bram_sel = bram_sel_q;
    assign core.hls_mode = hls_mode_q;
    assign res_valid_o   = res_valid_q;
    assign res_data_o    = res_data_q;
    assign res_mode_o    = res_mode_q;
    assign res_timeout_o = res_timeout_q;
    assign last_cycles_o = last_cycles_q;
endmodule

// File: tb/tb_hls_job_sequencer.sv
// Directed bench for hls_job_sequencer: normal jobs, same-cycle ready/done,
// timeout, ignored inputs, held-off ack and asynchronous reset mid-job.
module tb_hls_job_sequencer;
    import hls_pkg::*;

    localparam int RW  = 32;
    localparam int CW  = 32;
    localparam int TMO = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid, cmd_mode, cmd_ready, busy;
    logic          res_valid, res_ack, res_mode, res_timeout;
    logic [RW-1:0] res_data;
    logic [CW-1:0] last_cycles;

    int n_chk = 0;
    int n_err = 0;
    int starts;
    logic stable;

    hls_job_sequencer_if #(.RESULT_WIDTH(RW)) core_if ();

    hls_job_sequencer #(
        .TIMEOUT_CYCLES (TMO),
        .RESULT_WIDTH   (RW),
        .CYC_WIDTH      (CW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_valid_i   (cmd_valid),
        .cmd_mode_i    (cmd_mode),
        .cmd_ready_o   (cmd_ready),
        .core          (core_if),
        .busy_o        (busy),
        .res_valid_o   (res_valid),
        .res_ack_i     (res_ack),
        .res_data_o    (res_data),
        .res_mode_o    (res_mode),
        .res_timeout_o (res_timeout),
        .last_cycles_o (last_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst                = 1'b1;
        cmd_valid          = 1'b0;
        cmd_mode           = MODE_DOT;
        res_ack            = 1'b0;
        core_if.ap_ready   = 1'b0;
        core_if.ap_done    = 1'b0;
        core_if.hls_result = '0;
        #12;
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_ap_start", core_if.ap_start, 0);
        chk("rst_bram_sel", core_if.bram_sel, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_last_cycles", last_cycles, 0);
        rst = 1'b0;
        step();

        // Dot job: ap_ready in cycle 2, ap_done in cycle 10 (first ap_start cycle = 1)
        cmd_mode  = MODE_DOT;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        starts = 0;
        for (int k = 1; k <= 10; k++) begin
            if (core_if.ap_start) starts++;
            if (k == 1) chk("t1_bram_sel_job", core_if.bram_sel, 1);
            if (k == 10) chk("t1_no_early_valid", res_valid, 0);
            core_if.ap_ready   = (k == 2);
            core_if.ap_done    = (k == 10);
            core_if.hls_result = (k == 10) ? 32'h0000_1234 : 32'h0;
            step();
        end
        core_if.ap_ready   = 1'b0;
        core_if.ap_done    = 1'b0;
        core_if.hls_result = 32'hFFFF_FFFF;
        chk("t1_start_cycles", starts, 2);
        chk("t1_res_valid", res_valid, 1);
        chk("t1_res_data", res_data, 32'h1234);
        chk("t1_res_mode", res_mode, 0);
        chk("t1_last_cycles", last_cycles, 10);
        chk("t1_bram_sel_done", core_if.bram_sel, 0);
        chk("t1_timeout", res_timeout, 0);

        // Hold ack off 50 cycles with stray cmd_valid pulses in RESP
        stable = 1'b1;
        starts = 0;
        for (int i = 0; i < 50; i++) begin
            if (!res_valid || res_data != 32'h1234 || cmd_ready) stable = 1'b0;
            if (core_if.ap_start) starts++;
            cmd_valid = (i >= 20 && i < 25);
            step();
        end
        chk("t1_hold_stable", stable, 1);
        chk("t1_hold_no_start", starts, 0);
        res_ack = 1'b1;
        step();
        res_ack = 1'b0;
        chk("t1_ack_valid_low", res_valid, 0);
        chk("t1_ack_cmd_ready", cmd_ready, 1);
        chk("t1_ack_data_held", res_data, 32'h1234);

        // Euclidean job: ap_ready and ap_done together in the first START cycle
        cmd_mode  = MODE_EUC;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        chk("t2_ap_start", core_if.ap_start, 1);
        chk("t2_hls_mode", core_if.hls_mode, 1);
        core_if.ap_ready   = 1'b1;
        core_if.ap_done    = 1'b1;
        core_if.hls_result = 32'hDEAD_BEEF;
        step();
        core_if.ap_ready   = 1'b0;
        core_if.ap_done    = 1'b0;
        core_if.hls_result = 32'h0;
        chk("t2_ap_start_drop", core_if.ap_start, 0);
        chk("t2_res_valid", res_valid, 1);
        chk("t2_res_data", res_data, 32'hDEAD_BEEF);
        chk("t2_res_mode", res_mode, 1);
        chk("t2_last_cycles", last_cycles, 1);
        chk("t2_busy_resp", busy, 1);
        res_ack = 1'b1;
        step();
        res_ack = 1'b0;

        // Timeout: ap_ready in cycle 1, no ap_done; cmd_valid pulsed in RUN
        cmd_mode  = MODE_DOT;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        stable = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            if (k >= 2 && (core_if.ap_start || cmd_ready)) stable = 1'b0;
            if (k == 16) chk("t3_no_early_valid", res_valid, 0);
            core_if.ap_ready = (k == 1);
            cmd_valid        = (k >= 3 && k <= 5);
            step();
        end
        core_if.ap_ready = 1'b0;
        cmd_valid        = 1'b0;
        chk("t3_run_ignored_cmd", stable, 1);
        chk("t3_res_valid", res_valid, 1);
        chk("t3_res_timeout", res_timeout, 1);
        chk("t3_res_data", res_data, 0);
        chk("t3_bram_sel", core_if.bram_sel, 0);
        chk("t3_last_cycles", last_cycles, 32'hFFFF_FFFF);
        core_if.ap_done    = 1'b1;
        core_if.hls_result = 32'h5555_5555;
        step();
        core_if.ap_done = 1'b0;
        chk("t3_stray_done_timeout", res_timeout, 1);
        chk("t3_stray_done_data", res_data, 0);
        chk("t3_stray_done_busy", busy, 1);
        res_ack = 1'b1;
        step();
        res_ack = 1'b0;
        core_if.ap_done = 1'b1;
        step();
        core_if.ap_done = 1'b0;
        chk("t3_idle_done_valid", res_valid, 0);
        chk("t3_idle_done_busy", busy, 0);
        chk("t3_idle_done_bram", core_if.bram_sel, 0);

        // Asynchronous reset in RUN, between clock edges
        cmd_mode  = MODE_EUC;
        cmd_valid = 1'b1;
        step();
        cmd_valid        = 1'b0;
        core_if.ap_ready = 1'b1;
        step();
        core_if.ap_ready = 1'b0;
        step();
        chk("t4_pre_busy", busy, 1);
        #3;
        rst = 1'b1;
        #1;
        chk("t4_rst_busy", busy, 0);
        chk("t4_rst_cmd_ready", cmd_ready, 1);
        chk("t4_rst_bram_sel", core_if.bram_sel, 0);
        chk("t4_rst_hls_mode", core_if.hls_mode, 0);
        chk("t4_rst_timeout", res_timeout, 0);
        chk("t4_rst_last_cycles", last_cycles, 0);
        #2;
        rst = 1'b0;
        step();

        // Normal dot job after reset: ready+done in cycle 3
        cmd_mode  = MODE_DOT;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            core_if.ap_ready   = (k == 3);
            core_if.ap_done    = (k == 3);
            core_if.hls_result = 32'h0000_5A5A;
            step();
        end
        core_if.ap_ready = 1'b0;
        core_if.ap_done  = 1'b0;
        chk("t5_res_valid", res_valid, 1);
        chk("t5_res_data", res_data, 32'h5A5A);
        chk("t5_last_cycles", last_cycles, 3);
        chk("t5_timeout", res_timeout, 0);
        res_ack = 1'b1;
        step();
        res_ack = 1'b0;
        chk("t5_idle", cmd_ready, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
